// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: queues game events, expands each into a short
// note sequence for a downstream tone player, and hands GAME_OVER off to a
// dedicated melody player while halting all further effects.
module sfx_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        evt_valid,
  input  logic [1:0]  evt_code,
  output logic        note_valid,
  input  logic        note_ready,
  output logic [15:0] note_freq,
  output logic [15:0] note_dur,
  output logic        go_pulse,
  output logic        evt_full,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] EVT_MOVE       = 2'd0;
  localparam logic [1:0] EVT_ROTATE     = 2'd1;
  localparam logic [1:0] EVT_LINE_CLEAR = 2'd2;
  localparam logic [1:0] EVT_GAME_OVER  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_HALT} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_code;
  logic [1:0]    w_code_next;
  logic [1:0]    r_step;
  logic [1:0]    w_step_next;
  logic          r_go;
  logic [7:0]    r_drop_cnt;

  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_go;
  logic          w_is_sfx;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [1:0]    w_head;
  logic [15:0]   w_tab_freq;
  logic [15:0]   w_tab_dur;
  logic [1:0]    w_last_step;

  // Fullness is judged on the queue state at the start of the cycle, so a
  // pop in the same cycle never makes room for an incoming event.
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_go     = evt_valid && (evt_code == EVT_GAME_OVER) && (r_state != S_HALT);
  assign w_is_sfx = evt_valid && (evt_code != EVT_GAME_OVER) && (r_state != S_HALT);
  assign w_push   = w_is_sfx && !w_full;
  assign w_drop   = w_is_sfx && w_full;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0) && !w_go;
  assign w_head   = r_mem[r_rd_ptr];

  // Queue storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= evt_code;
    end
  end

  // Queue pointers and occupancy; GAME_OVER flushes everything at once.
  always_ff @(posedge clk) begin
    if (reset || w_go) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of events lost to a full queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Sequencer state, current event, note index and melody start strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_code  <= EVT_MOVE;
      r_step  <= '0;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_step  <= w_step_next;
      r_go    <= w_go;
    end
  end

  // Next-state logic; GAME_OVER overrides any pop or note handshake.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_step_next  = r_step;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_next = S_EMIT;
          w_code_next  = w_head;
          w_step_next  = '0;
        end
      end
      S_EMIT: begin
        if (note_ready) begin
          if (r_step == w_last_step) begin
            w_state_next = S_IDLE;
          end else begin
            w_step_next = r_step + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_HALT;
      end
    endcase
    if (w_go) begin
      w_state_next = S_HALT;
      w_step_next  = '0;
    end
  end

  // Note table indexed by the latched event code and note index.
  always_comb begin
    w_tab_freq  = 16'd0;
    w_tab_dur   = 16'd0;
    w_last_step = 2'd0;
    case (r_code)
      EVT_MOVE: begin
        w_tab_freq = 16'd440;
        w_tab_dur  = 16'd30;
      end
      EVT_ROTATE: begin
        w_tab_freq = 16'd523;
        w_tab_dur  = 16'd40;
      end
      EVT_LINE_CLEAR: begin
        w_last_step = 2'd2;
        case (r_step)
          2'd0:    begin w_tab_freq = 16'd523; w_tab_dur = 16'd80;  end
          2'd1:    begin w_tab_freq = 16'd659; w_tab_dur = 16'd80;  end
          default: begin w_tab_freq = 16'd784; w_tab_dur = 16'd120; end
        endcase
      end
      default: begin
        w_tab_freq = 16'd0;
        w_tab_dur  = 16'd0;
      end
    endcase
  end

  assign note_valid = (r_state == S_EMIT);
  assign note_freq  = note_valid ? w_tab_freq : 16'd0;
  assign note_dur   = note_valid ? w_tab_dur  : 16'd0;
  assign go_pulse   = r_go;
  assign evt_full   = w_full;
  assign drop_cnt   = r_drop_cnt;
  assign busy       = (r_count != '0) || (r_state != S_IDLE);

endmodule

// File: doc/sfx_sequencer.md
SFX_SEQUENCER -- requirements
Module: sfx_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event queue depth (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port evt_valid  input  1  game logic offers a sound event this cycle.
REQ-005 SHALL have port evt_code  input  2  event: 0 MOVE, 1 ROTATE, 2 LINE_CLEAR, 3 GAME_OVER.
REQ-006 SHALL have port note_valid  output  1  note request to the downstream tone player is valid.
REQ-007 SHALL have port note_ready  input  1  tone player accepts the current note.
REQ-008 SHALL have port note_freq  output  16  note frequency in Hz (0 = rest).
REQ-009 SHALL have port note_dur  output  16  note duration in ms.
REQ-010 SHALL have port go_pulse  output  1  one-cycle start strobe to the game-over melody player.
REQ-011 SHALL have port evt_full  output  1  queue full; new non-GAME_OVER events are dropped.
REQ-012 SHALL have port drop_cnt  output  8  count of dropped events, saturating at 255.
REQ-013 SHALL have port busy  output  1  high when the queue is non-empty or state is not IDLE.

Function
REQ-014 SHALL accept a MOVE/ROTATE/LINE_CLEAR event when evt_valid=1 and the queue is not full at the start of the cycle; the entry is visible in the queue on the next cycle.
REQ-015 SHALL drop a MOVE/ROTATE/LINE_CLEAR event offered while full, incrementing drop_cnt by 1 (no wrap past 255); a simultaneous pop does not rescue it.
REQ-016 SHALL ignore pop requests when the queue is empty; read/write pointers wrap modulo FIFO_DEPTH; evt_full = (count == FIFO_DEPTH).
REQ-017 SHALL implement FSM states IDLE, EMIT, HALT.
REQ-018 SHALL, in IDLE with a non-empty queue, pop the head entry, latch its code, set step=0, and go to EMIT; note_valid rises the cycle after the pop (event offered at cycle N -> note_valid at N+2).
REQ-019 SHALL expand codes via fixed tables: MOVE = 1 note {440 Hz, 30 ms}; ROTATE = 1 note {523 Hz, 40 ms}; LINE_CLEAR = 3 notes {523, 80}, {659, 80}, {784, 120}.
REQ-020 SHALL, in EMIT, hold note_valid=1 with note_freq/note_dur stable from table(code, step) until note_ready=1.
REQ-021 SHALL, on a handshake (note_valid & note_ready), advance step if notes remain (next note valid the following cycle with no bubble), else return to IDLE with note_valid=0 the following cycle.
REQ-022 SHALL hold note_freq and note_dur at 0 whenever note_valid=0.
REQ-023 SHALL, on an offered GAME_OVER event in any state except HALT, ignore queue fullness, flush the queue, abort any note in progress, drive go_pulse=1 for exactly the next cycle, and enter HALT; note_valid is 0 from that next cycle on.
REQ-024 SHALL give GAME_OVER priority over a simultaneous pop or note handshake in the same cycle; the handshake still counts as accepted downstream, but no further note is issued.
REQ-025 SHALL, in HALT, ignore all events without counting them as drops, hold note_valid=0 and go_pulse=0, and leave HALT only on reset.
REQ-026 SHALL never let drop_cnt change except as in REQ-015.

Reset
REQ-027 SHALL, when reset=1 at a rising clk, empty the queue, zero the pointers and step, enter IDLE, and force note_valid=0, note_freq=0, note_dur=0, go_pulse=0, evt_full=0, drop_cnt=0, busy=0 from the next cycle, including mid-sequence and in HALT.
REQ-028 SHALL give reset priority over every other input in the same cycle; events offered during reset are discarded.

Verification
REQ-029 SHALL verify: MOVE at cycle 10, note_ready=1 -> note_valid=1 at cycle 12 with 440/30, low at cycle 13, busy low at cycle 13.
REQ-030 SHALL verify: LINE_CLEAR with note_ready held 0 for 5 cycles, then 1 -> 523/80 held stable all 5 cycles, then 659/80 and 784/120 on consecutive cycles.
REQ-031 SHALL verify: 6 back-to-back ROTATE events, note_ready=0 -> 1 popped into EMIT, 4 queued, evt_full=1, drop_cnt=1.
REQ-032 SHALL verify: drop_cnt driven to 255 and then 3 more drops -> drop_cnt remains 255.
REQ-033 SHALL verify: GAME_OVER mid-LINE_CLEAR with a full queue -> go_pulse high for exactly 1 cycle, note_valid=0 and queue empty from the next cycle, later events ignored, drop_cnt unchanged.
REQ-034 SHALL verify: reset asserted while in HALT -> all outputs 0 next cycle; a following MOVE plays normally.
